// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: opcodes, state encoding, pc_sel/wb_sel codes and instruction-class type shared by the controller
package multicycle_controller_pkg;
  localparam logic [6:0] R_TYPE             = 7'b0110011;
  localparam logic [6:0] I_TYPE_CALCUTATION = 7'b0010011;
  localparam logic [6:0] I_TYPE_JALR        = 7'b1100111;
  localparam logic [6:0] LOAD               = 7'b0000011;
  localparam logic [6:0] STORE              = 7'b0100011;
  localparam logic [6:0] B_TYPE             = 7'b1100011;
  localparam logic [6:0] J_TYPE             = 7'b1101111;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;
  localparam logic [1:0] WB_ALU   = 2'b00;
  localparam logic [1:0] WB_MEM   = 2'b01;
  localparam logic [1:0] WB_PC4   = 2'b10;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_t;
  typedef struct packed {
    logic r;
    logic i;
    logic jalr;
    logic ld;
    logic st;
    logic br;
    logic j;
  } iclass_t;
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: controller<->datapath bundle (inst/mem_ready/branch_taken in; memory, pc, alu, regfile strobes and status out)
interface multicycle_controller_if;
  logic [31:0] inst;
  logic        mem_ready;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        alu_a_sel;
  logic        alu_b_sel;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        inst_retired;
  logic        illegal;
  logic [2:0]  state;
  modport master (
    input  inst, mem_ready, branch_taken,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel,
           alu_b_sel, reg_we, wb_sel, inst_retired, illegal, state
  );
  modport slave (
    output inst, mem_ready, branch_taken,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, alu_a_sel,
           alu_b_sel, reg_we, wb_sel, inst_retired, illegal, state
  );
endinterface

// File: rtl/multicycle_controller_opcode_class_decoder.sv
// opcode_class_decoder: maps opcode[6:0] to a one-hot instruction class (cls) and a supported flag (valid)
module opcode_class_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       valid
);
  assign cls.r    = opcode == R_TYPE;
  assign cls.i    = opcode == I_TYPE_CALCUTATION;
  assign cls.jalr = opcode == I_TYPE_JALR;
  assign cls.ld   = opcode == LOAD;
  assign cls.st   = opcode == STORE;
  assign cls.br   = opcode == B_TYPE;
  assign cls.j    = opcode == J_TYPE;
  assign valid    = |cls;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32I fetch/decode/exec/mem/wb sequencer; clk, sync active-low rst_n, bus = master side of multicycle_controller_if
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input logic                   clk,
  input logic                   rst_n,
  multicycle_controller_if.master bus
);
  state_t  st;
  iclass_t c;
  logic    valid;
  logic    fe, ex, me, wb, rdy, ret_ex, ret_me;
  logic    unused;
  opcode_class_decoder u_dec (.opcode(bus.inst[6:0]), .cls(c), .valid(valid));
  assign unused = ^bus.inst[31:7];
  always_ff @(posedge clk) begin
    if (!rst_n) st <= IDLE;
    else case (st)
      IDLE:    st <= FETCH;
      FETCH:   st <= bus.mem_ready ? DECODE : FETCH;
      DECODE:  st <= valid ? EXEC : HALT;
      EXEC:    st <= (c.r | c.i) ? WB : (c.ld | c.st) ? MEM : FETCH;
      MEM:     st <= !bus.mem_ready ? MEM : c.st ? FETCH : WB;
      WB:      st <= FETCH;
      HALT:    st <= HALT;
      default: st <= IDLE;
    endcase
  end
  assign fe     = st == FETCH;
  assign ex     = st == EXEC;
  assign me     = st == MEM;
  assign wb     = st == WB;
  assign rdy    = bus.mem_ready;
  assign ret_ex = ex & (c.br | c.j | c.jalr);
  assign ret_me = me & c.st & rdy;
  assign bus.mem_req      = fe | me;
  assign bus.mem_we       = me & c.st;
  assign bus.mem_addr_sel = me;
  assign bus.ir_we        = fe & rdy;
  assign bus.pc_we        = ret_ex | ret_me | wb;
  assign bus.inst_retired = ret_ex | ret_me | wb;
  assign bus.pc_sel       = (ex & (c.j | (c.br & bus.branch_taken))) ? PC_IMM :
                            (ex & c.jalr) ? PC_ALU : PC_PLUS4;
  assign bus.alu_a_sel    = ex & c.j;
  assign bus.alu_b_sel    = me | (ex & (c.i | c.ld | c.st | c.j | c.jalr));
  assign bus.reg_we       = wb | (ex & (c.j | c.jalr));
  assign bus.wb_sel       = (wb & c.ld) ? WB_MEM : (ex & (c.j | c.jalr)) ? WB_PC4 : WB_ALU;
  assign bus.illegal      = st == HALT;
  assign bus.state        = st;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-scenario checks of the multicycle controller state sequence and strobes
module tb_multicycle_controller;
  logic clk = 0;
  logic rst_n = 0;
  int vecs = 0;
  int errs = 0;
  multicycle_controller_if b ();
  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  logic [16:0] obs;
  assign obs = {b.state, b.mem_req, b.mem_we, b.mem_addr_sel, b.ir_we, b.pc_we, b.pc_sel,
                b.alu_a_sel, b.alu_b_sel, b.reg_we, b.wb_sel, b.inst_retired, b.illegal};
  function automatic logic [16:0] e(input logic [2:0] st, input logic mr, mw, ma, ir, pw,
                                    input logic [1:0] ps, input logic aa, ab, rw,
                                    input logic [1:0] ws, input logic rt, il);
    return {st, mr, mw, ma, ir, pw, ps, aa, ab, rw, ws, rt, il};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    b.inst = 32'h0;
    b.mem_ready = 0;
    b.branch_taken = 0;
    tick;
    vecs++;
    if (obs !== e(0,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      errs++;
      $display("FAIL reset_idle got %h exp %h", obs, e(0,0,0,0,0,0,0,0,0,0,0,0,0));
    end
    rst_n = 1;
    #1;
    vecs++;
    if (obs !== e(0,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      errs++;
      $display("FAIL reset_release got %h exp %h", obs, e(0,0,0,0,0,0,0,0,0,0,0,0,0));
    end
    tick;
    vecs++;
    if (obs !== e(1,1,0,0,0,0,0,0,0,0,0,0,0)) begin
      errs++;
      $display("FAIL reset_first_fetch got %h exp %h", obs, e(1,1,0,0,0,0,0,0,0,0,0,0,0));
    end
  endtask
  task automatic test_add;
    logic [16:0] x [5];
    logic r [5];
    x = '{e(1,1,0,0,1,0,0,0,0,0,0,0,0), e(2,0,0,0,0,0,0,0,0,0,0,0,0),
          e(3,0,0,0,0,0,0,0,0,0,0,0,0), e(5,0,0,0,0,1,0,0,0,1,0,1,0),
          e(1,1,0,0,0,0,0,0,0,0,0,0,0)};
    r = '{1, 0, 0, 0, 0};
    b.inst = 32'h002081B3;
    for (int i = 0; i < 5; i++) begin
      b.mem_ready = r[i];
      #1;
      vecs++;
      if (obs !== x[i]) begin
        errs++;
        $display("FAIL add_c%0d got %h exp %h", i, obs, x[i]);
      end
      if (i < 4) tick;
    end
  endtask
  task automatic test_lw;
    logic [16:0] x [9];
    logic r [9];
    x = '{e(1,1,0,0,1,0,0,0,0,0,0,0,0), e(2,0,0,0,0,0,0,0,0,0,0,0,0),
          e(3,0,0,0,0,0,0,0,1,0,0,0,0), e(4,1,0,1,0,0,0,0,1,0,0,0,0),
          e(4,1,0,1,0,0,0,0,1,0,0,0,0), e(4,1,0,1,0,0,0,0,1,0,0,0,0),
          e(4,1,0,1,0,0,0,0,1,0,0,0,0), e(5,0,0,0,0,1,0,0,0,1,1,1,0),
          e(1,1,0,0,0,0,0,0,0,0,0,0,0)};
    r = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    b.inst = 32'h0080A283;
    for (int i = 0; i < 9; i++) begin
      b.mem_ready = r[i];
      #1;
      vecs++;
      if (obs !== x[i]) begin
        errs++;
        $display("FAIL lw_c%0d got %h exp %h", i, obs, x[i]);
      end
      if (i < 8) tick;
    end
  endtask
  task automatic test_sw;
    logic [16:0] x [5];
    logic r [5];
    x = '{e(1,1,0,0,1,0,0,0,0,0,0,0,0), e(2,0,0,0,0,0,0,0,0,0,0,0,0),
          e(3,0,0,0,0,0,0,0,1,0,0,0,0), e(4,1,1,1,0,1,0,0,1,0,0,1,0),
          e(1,1,0,0,0,0,0,0,0,0,0,0,0)};
    r = '{1, 0, 0, 1, 0};
    b.inst = 32'h0020A223;
    for (int i = 0; i < 5; i++) begin
      b.mem_ready = r[i];
      #1;
      vecs++;
      if (obs !== x[i]) begin
        errs++;
        $display("FAIL sw_c%0d got %h exp %h", i, obs, x[i]);
      end
      if (i < 4) tick;
    end
  endtask
  task automatic test_beq(input logic bt);
    logic [16:0] x [4];
    logic r [4];
    x = '{e(1,1,0,0,1,0,0,0,0,0,0,0,0), e(2,0,0,0,0,0,0,0,0,0,0,0,0),
          e(3,0,0,0,0,1,{1'b0, bt},0,0,0,0,1,0), e(1,1,0,0,0,0,0,0,0,0,0,0,0)};
    r = '{1, 1, 1, 0};
    b.inst = 32'h00208463;
    b.branch_taken = bt;
    for (int i = 0; i < 4; i++) begin
      b.mem_ready = r[i];
      #1;
      vecs++;
      if (obs !== x[i]) begin
        errs++;
        $display("FAIL beq%0d_c%0d got %h exp %h", bt, i, obs, x[i]);
      end
      if (i < 3) tick;
    end
    b.branch_taken = 0;
  endtask
  task automatic test_jal;
    logic [16:0] x [4];
    x = '{e(1,1,0,0,1,0,0,0,0,0,0,0,0), e(2,0,0,0,0,0,0,0,0,0,0,0,0),
          e(3,0,0,0,0,1,1,1,1,1,2,1,0), e(1,1,0,0,0,0,0,0,0,0,0,0,0)};
    b.inst = 32'h010000EF;
    for (int i = 0; i < 4; i++) begin
      b.mem_ready = (i == 0);
      #1;
      vecs++;
      if (obs !== x[i]) begin
        errs++;
        $display("FAIL jal_c%0d got %h exp %h", i, obs, x[i]);
      end
      if (i < 3) tick;
    end
  endtask
  task automatic test_jalr;
    logic [16:0] x [4];
    x = '{e(1,1,0,0,1,0,0,0,0,0,0,0,0), e(2,0,0,0,0,0,0,0,0,0,0,0,0),
          e(3,0,0,0,0,1,2,0,1,1,2,1,0), e(1,1,0,0,0,0,0,0,0,0,0,0,0)};
    b.inst = 32'h000080E7;
    for (int i = 0; i < 4; i++) begin
      b.mem_ready = (i == 0);
      #1;
      vecs++;
      if (obs !== x[i]) begin
        errs++;
        $display("FAIL jalr_c%0d got %h exp %h", i, obs, x[i]);
      end
      if (i < 3) tick;
    end
  endtask
  task automatic test_addi_fetch_wait;
    logic [16:0] x [7];
    logic r [7];
    x = '{e(1,1,0,0,0,0,0,0,0,0,0,0,0), e(1,1,0,0,0,0,0,0,0,0,0,0,0),
          e(1,1,0,0,1,0,0,0,0,0,0,0,0), e(2,0,0,0,0,0,0,0,0,0,0,0,0),
          e(3,0,0,0,0,0,0,0,1,0,0,0,0), e(5,0,0,0,0,1,0,0,0,1,0,1,0),
          e(1,1,0,0,0,0,0,0,0,0,0,0,0)};
    r = '{0, 0, 1, 0, 0, 0, 0};
    b.inst = 32'h00500093;
    for (int i = 0; i < 7; i++) begin
      b.mem_ready = r[i];
      #1;
      vecs++;
      if (obs !== x[i]) begin
        errs++;
        $display("FAIL addi_c%0d got %h exp %h", i, obs, x[i]);
      end
      if (i < 6) tick;
    end
  endtask
  task automatic test_reset_mid_mem;
    logic [16:0] x [6];
    logic r [6];
    logic n [6];
    x = '{e(1,1,0,0,1,0,0,0,0,0,0,0,0), e(2,0,0,0,0,0,0,0,0,0,0,0,0),
          e(3,0,0,0,0,0,0,0,1,0,0,0,0), e(4,1,0,1,0,0,0,0,1,0,0,0,0),
          e(0,0,0,0,0,0,0,0,0,0,0,0,0), e(1,1,0,0,0,0,0,0,0,0,0,0,0)};
    r = '{1, 0, 0, 0, 0, 0};
    n = '{1, 1, 1, 0, 1, 1};
    b.inst = 32'h0080A283;
    for (int i = 0; i < 6; i++) begin
      b.mem_ready = r[i];
      #1;
      vecs++;
      if (obs !== x[i]) begin
        errs++;
        $display("FAIL rst_mem_c%0d got %h exp %h", i, obs, x[i]);
      end
      rst_n = n[i];
      if (i < 5) tick;
    end
    rst_n = 1;
  endtask
  task automatic test_illegal;
    b.inst = 32'h0000007F;
    b.mem_ready = 1;
    #1;
    vecs++;
    if (obs !== e(1,1,0,0,1,0,0,0,0,0,0,0,0)) begin
      errs++;
      $display("FAIL ill_fetch got %h exp %h", obs, e(1,1,0,0,1,0,0,0,0,0,0,0,0));
    end
    tick;
    vecs++;
    if (obs !== e(2,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      errs++;
      $display("FAIL ill_decode got %h exp %h", obs, e(2,0,0,0,0,0,0,0,0,0,0,0,0));
    end
    for (int i = 0; i < 20; i++) begin
      tick;
      b.mem_ready = i[0];
      b.branch_taken = i[1];
      #1;
      vecs++;
      if (obs !== e(6,0,0,0,0,0,0,0,0,0,0,0,1)) begin
        errs++;
        $display("FAIL halt_c%0d got %h exp %h", i, obs, e(6,0,0,0,0,0,0,0,0,0,0,0,1));
      end
    end
    b.mem_ready = 0;
    b.branch_taken = 0;
    rst_n = 0;
    tick;
    vecs++;
    if (obs !== e(0,0,0,0,0,0,0,0,0,0,0,0,0)) begin
      errs++;
      $display("FAIL halt_reset got %h exp %h", obs, e(0,0,0,0,0,0,0,0,0,0,0,0,0));
    end
    rst_n = 1;
    tick;
    vecs++;
    if (obs !== e(1,1,0,0,0,0,0,0,0,0,0,0,0)) begin
      errs++;
      $display("FAIL halt_refetch got %h exp %h", obs, e(1,1,0,0,0,0,0,0,0,0,0,0,0));
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_lw;
    test_sw;
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal;
    test_jalr;
    test_addi_fetch_wait;
    test_reset_mid_mem;
    test_illegal;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Multi-cycle sequencer for the RV32I core datapath. It walks each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the register-file, PC, ALU-operand, memory and writeback select strobes from the instruction-register opcode. It sits beside the immediate generator and the ALU. It owns the shared memory port, used both for instruction fetch and for load/store data, and halts on unsupported opcodes.

## Interface
- No parameters; opcode and state encodings come from `define_constant.v`.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset: the block uses one clock, and reset is sampled on the rising edge of clk.
- inst  in  32  instruction-register output; only inst[6:0] is decoded.
- mem_ready  in  1  memory access complete this cycle; ignored while mem_req=0.
- branch_taken  in  1  comparator result for the current B_TYPE instruction.
- mem_req  out  1  memory access request.
- mem_we  out  1  write (store) qualifier for mem_req.
- mem_addr_sel  out  1  memory address source: 0=PC, 1=ALU result.
- ir_we  out  1  load the instruction register from memory read data.
- pc_we  out  1  update the PC.
- pc_sel  out  2  next-PC source: 00=PC+4, 01=PC+imm, 10=ALU result with bit0 cleared (JALR).
- alu_a_sel  out  1  ALU operand A: 0=rs1, 1=PC.
- alu_b_sel  out  1  ALU operand B: 0=rs2, 1=imm.
- reg_we  out  1  register-file write enable.
- wb_sel  out  2  writeback source: 00=ALU, 01=memory data, 10=PC+4.
- inst_retired  out  1  one-cycle pulse in the final cycle of each instruction.
- illegal  out  1  high while the block is in HALT.
- state  out  3  current state, for debug and coverage.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Outputs are combinational from the state and inst[6:0]; the state is a register.
- Any output not listed for a state is 0.
- IDLE: all outputs 0; goes to FETCH unconditionally.
- FETCH: mem_req=1, mem_addr_sel=0. Holds until mem_ready. On the mem_ready cycle it asserts ir_we=1 and goes to DECODE.
- DECODE: one cycle for the register read and immediate settle.
  - Opcode not one of R_TYPE, I_TYPE_CALCUTATION, I_TYPE_JALR, LOAD, STORE, B_TYPE, J_TYPE: go to HALT.
  - Otherwise go to EXEC.
- EXEC, by opcode:
  - R_TYPE: alu_b_sel=0; go to WB.
  - I_TYPE_CALCUTATION: alu_b_sel=1; go to WB.
  - LOAD/STORE: alu_b_sel=1; go to MEM.
  - B_TYPE: pc_we=1, pc_sel=branch_taken?01:00, inst_retired=1; go to FETCH.
  - J_TYPE: alu_a_sel=1, alu_b_sel=1, pc_we=1, pc_sel=01, reg_we=1, wb_sel=10, inst_retired=1; go to FETCH.
  - I_TYPE_JALR: alu_b_sel=1, pc_we=1, pc_sel=10, reg_we=1, wb_sel=10, inst_retired=1; go to FETCH.
- MEM: mem_req=1, mem_addr_sel=1, alu_b_sel=1, mem_we=(opcode==STORE). Holds until mem_ready.
  - STORE: on mem_ready, pc_we=1, pc_sel=00, inst_retired=1; go to FETCH.
  - LOAD: on mem_ready, go to WB.
- WB: reg_we=1, wb_sel=01 for LOAD and 00 otherwise; pc_we=1, pc_sel=00, inst_retired=1; go to FETCH.
- HALT: all outputs 0 except illegal=1; remains until reset.
- PC+4 on the writeback path uses the pre-update PC; the PC and the register file commit on the same edge.

## Timing
- Reset: rst_n=0 on an edge puts the state in IDLE. All outputs are then 0 from the following cycle.
- Reset mid-operation abandons any pending access. Memory must tolerate mem_req dropping without mem_ready.
- First fetch request appears 1 cycle after rst_n returns high (IDLE→FETCH).
- Latency with zero-wait memory (mem_ready in the first request cycle):
  - B_TYPE/J_TYPE/JALR: 3 cycles.
  - R_TYPE, I_TYPE_CALCUTATION, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Handshake: mem_req, mem_we and mem_addr_sel are held stable from the first request cycle through the mem_ready cycle. mem_ready while not requesting has no effect.
- inst is stable from DECODE through the end of the instruction, because ir_we is asserted only in FETCH.
- At most one inst_retired per instruction, and never in HALT.

## Structure
- `define_constant.v` (shared include): opcode constants and the 3-bit state encodings (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6). It also holds the pc_sel and wb_sel code constants.
- One sub-module, `opcode_class_decoder`: combinational, maps inst[6:0] to a one-hot instruction class plus a valid flag. The FSM consumes only the class.

## Test plan
- ADD x3,x1,x2 (0x002081B3), mem_ready immediate:
  - States FETCH, DECODE, EXEC, WB.
  - In the 4th cycle: reg_we=1, wb_sel=00, pc_we=1, pc_sel=00, inst_retired=1.
- LW x5,8(x1) (0x0080A283), data mem_ready delayed 3 cycles:
  - MEM held 4 cycles with mem_addr_sel=1, mem_we=0.
  - Then WB with wb_sel=01; total 8 cycles.
- SW x2,4(x1) (0x0020A223):
  - MEM cycle shows mem_req=1, mem_we=1.
  - Retires in MEM with pc_sel=00, reg_we never 1.
- BEQ (0x00208463):
  - branch_taken=1: EXEC gives pc_we=1, pc_sel=01.
  - branch_taken=0: pc_sel=00.
  - Both retire in cycle 3.
- JAL x1,+16 (0x010000EF):
  - EXEC gives pc_sel=01, reg_we=1, wb_sel=10.
  - Next state is FETCH.
- Illegal/reset:
  - inst=0x0000007F: DECODE→HALT, illegal=1, held for 20 cycles.
  - rst_n=0 for 1 edge: IDLE, then FETCH.
  - rst_n=0 asserted during MEM: mem_req=0 the next cycle.
